// File: rtl/api_resp_pkg.sv
// api_resp_pkg: shared constants, state encoding and result-word builder for api_chip_resp
// Ports: none (package).
package api_resp_pkg;
    localparam int WORK_LEN = 23;
    localparam int RX_BLOCK_LEN = 11;
    localparam int NONCE_FIFO_DEPTH = 4;
    localparam int LVL_W = $clog2(NONCE_FIFO_DEPTH) + 1;
    localparam logic [4:0] LAST_WORD = 5'(WORK_LEN - 1);
    localparam logic [31:0] NONCE_MARKER = 32'hbeafbeaf;
    localparam logic [31:0] TX_IDLE_WORD = 32'hffffffff;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    // Result words 1..22; word 0 carries the popped nonce and is built at frame start.
    function automatic logic [31:0] tx_word(
        input logic [4:0]  idx,
        input logic        hit,
        input logic [3:0]  lvl,
        input logic [15:0] status
    );
        return idx >= 5'(RX_BLOCK_LEN) ? TX_IDLE_WORD :
               idx == 5'd1  ? {28'd0, lvl} :
               idx == 5'd9  ? (hit ? NONCE_MARKER : 32'd0) :
               idx == 5'd10 ? {status, 16'h0} : 32'd0;
    endfunction
endpackage

// File: rtl/api_resp_fifo.sv
// api_resp_fifo: 32-bit synchronous show-ahead FIFO with level, full and empty
// Ports: clk/rst (sync, active-high); push_i/din_i write side; pop_i read side with
//        dout_o showing the head entry; level_o entry count; full_o/empty_o registered flags.
module api_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [31:0] din_i,
    input  logic        pop_i,
    output logic [31:0] dout_o,
    output logic [AW:0] level_o,
    output logic        full_o,
    output logic        empty_o
);
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, empty_q;

    assign cnt_d   = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    assign dout_o  = mem_q[rd_q];
    assign level_o = cnt_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_q + AW'(push_i);
            rd_q    <= rd_q + AW'(pop_i);
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == (AW+1)'(DEPTH);
            empty_q <= cnt_d == '0;
        end
    end
endmodule

// File: rtl/api_chip_resp.sv
// api_chip_resp: chip-side responder for the miner API serial link
// Ports: clk/rst (sync, active-high); sck/mosi/load serial inputs from the controller
//        (load active-low, asynchronous to clk); miso result block, MSB first;
//        work_vld/work_idx/work_dat received work words; frame_done/frame_err frame pulses;
//        nonce_wr_en/nonce_din/nonce_full/nonce_ovf nonce queue; chip_status for word 10.
module api_chip_resp
    import api_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sck,
    input  logic        mosi,
    input  logic        load,
    output logic        miso,
    output logic        work_vld,
    output logic [4:0]  work_idx,
    output logic [31:0] work_dat,
    output logic        frame_done,
    output logic        frame_err,
    input  logic        nonce_wr_en,
    input  logic [31:0] nonce_din,
    output logic        nonce_full,
    output logic        nonce_ovf,
    input  logic [15:0] chip_status
);
    logic [1:0]       sck_sync_q, mosi_sync_q, load_sync_q;
    logic             sck_prev_q, load_prev_q;
    logic             sck_s, mosi_s, load_s, rise_p, fall_p, load_fall, load_rise;
    state_e           state_q, state_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d, word_cnt_q, word_cnt_d;
    logic [31:0]      rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
    logic             hit_q, hit_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [15:0]      status_q, status_d;
    logic             work_vld_q, work_vld_d, frame_done_q, frame_done_d, frame_err_q, frame_err_d;
    logic [4:0]       work_idx_q, work_idx_d;
    logic [31:0]      work_dat_q, work_dat_d;
    logic             ovf_q, ovf_d;
    logic             pop, push, fifo_full, fifo_empty;
    logic [31:0]      fifo_dout;
    logic [LVL_W-1:0] fifo_level;

    assign sck_s     = sck_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign load_s    = load_sync_q[1];
    assign rise_p    = sck_s & ~sck_prev_q;
    assign fall_p    = ~sck_s & sck_prev_q;
    assign load_fall = ~load_s & load_prev_q;
    assign load_rise = load_s & ~load_prev_q;

    // A push into a full queue only lands when a pop frees a slot in the same clk.
    assign push = nonce_wr_en & (~fifo_full | pop);

    assign miso       = tx_sr_q[31];
    assign work_vld   = work_vld_q;
    assign work_idx   = work_idx_q;
    assign work_dat   = work_dat_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign nonce_full = fifo_full;
    assign nonce_ovf  = ovf_q;

    api_resp_fifo #(.DEPTH(NONCE_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (nonce_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        hit_d        = hit_q;
        lvl_d        = lvl_q;
        status_d     = status_q;
        work_vld_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        work_idx_d   = work_idx_q;
        work_dat_d   = work_dat_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                tx_sr_d = TX_IDLE_WORD;
                if (load_fall) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    pop        = ~fifo_empty;
                    hit_d      = ~fifo_empty;
                    lvl_d      = fifo_level - LVL_W'(pop);
                    status_d   = chip_status;
                    tx_sr_d    = pop ? fifo_dout : 32'd0;
                end
            end
            SHIFT: begin
                if (load_rise) begin
                    state_d     = IDLE;
                    frame_err_d = bit_cnt_q != 5'd0 || word_cnt_q != 5'd0;
                    tx_sr_d     = TX_IDLE_WORD;
                end else begin
                    // bit_cnt==0 on a fall means a fresh word was just loaded; keep its MSB.
                    if (fall_p && bit_cnt_q != 5'd0) tx_sr_d = {tx_sr_q[30:0], 1'b1};
                    if (rise_p) begin
                        rx_sr_d   = {rx_sr_q[30:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd31) begin
                            work_vld_d   = 1'b1;
                            work_idx_d   = word_cnt_q;
                            work_dat_d   = rx_sr_d;
                            frame_done_d = word_cnt_q == LAST_WORD;
                            state_d      = word_cnt_q == LAST_WORD ? DONE : SHIFT;
                            word_cnt_d   = word_cnt_q == LAST_WORD ? word_cnt_q : word_cnt_q + 5'd1;
                            tx_sr_d      = tx_word(word_cnt_q + 5'd1, hit_q, 4'(lvl_q), status_q);
                        end
                    end
                end
            end
            DONE: begin
                state_d = load_s ? IDLE : DONE;
                tx_sr_d = load_s ? TX_IDLE_WORD : tx_sr_q;
            end
            default: state_d = IDLE;
        endcase
        ovf_d = ovf_q | (nonce_wr_en & fifo_full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q   <= '0;
            mosi_sync_q  <= '0;
            load_sync_q  <= '1;
            sck_prev_q   <= 1'b0;
            load_prev_q  <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= TX_IDLE_WORD;
            hit_q        <= 1'b0;
            lvl_q        <= '0;
            status_q     <= '0;
            work_vld_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            work_idx_q   <= '0;
            work_dat_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            sck_sync_q   <= {sck_sync_q[0], sck};
            mosi_sync_q  <= {mosi_sync_q[0], mosi};
            load_sync_q  <= {load_sync_q[0], load};
            sck_prev_q   <= sck_s;
            load_prev_q  <= load_s;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            hit_q        <= hit_d;
            lvl_q        <= lvl_d;
            status_q     <= status_d;
            work_vld_q   <= work_vld_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            work_idx_q   <= work_idx_d;
            work_dat_q   <= work_dat_d;
            ovf_q        <= ovf_d;
        end
    end
endmodule
